// File: rtl/pressure_alarm_monitor_pkg.sv
// rtl/pressure_alarm_monitor_pkg.sv - shared types and constants for the pressure alarm monitor
package pressure_alarm_monitor_pkg;

   localparam int DEFAULT_DATA_W = 12;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      PEND_HI = 2'd1,
      ALARM   = 2'd2,
      PEND_LO = 2'd3
   } state_t;

   // Debounce counter must hold values 0..debounce inclusive.
   function automatic int cnt_width(input int debounce);
      return $clog2(debounce + 1);
   endfunction

endpackage

// File: rtl/pressure_alarm_monitor_if.sv
// rtl/pressure_alarm_monitor_if.sv - sample/threshold inputs and alarm/average outputs bundle
interface pressure_alarm_monitor_if
   import pressure_alarm_monitor_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);
   logic              sample_valid;
   logic [DATA_W-1:0] sample;
   logic [DATA_W-1:0] thresh_hi;
   logic [DATA_W-1:0] thresh_lo;
   logic [DATA_W-1:0] avg_out;
   logic              avg_valid;
   logic              alarm;
   logic              alarm_set;
   logic              alarm_clr;
   logic [1:0]        state_out;

   modport master (
      output sample_valid, sample, thresh_hi, thresh_lo,
      input  avg_out, avg_valid, alarm, alarm_set, alarm_clr, state_out
   );

   modport slave (
      input  sample_valid, sample, thresh_hi, thresh_lo,
      output avg_out, avg_valid, alarm, alarm_set, alarm_clr, state_out
   );
endinterface

// File: rtl/pressure_moving_avg.sv
// rtl/pressure_moving_avg.sv - power-of-two window moving average with warm-up gating
module pressure_moving_avg
   import pressure_alarm_monitor_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid_i,
   input  logic [DATA_W-1:0] sample_i,
   output logic              avg_valid_o,
   output logic [DATA_W-1:0] avg_o
);
   localparam int N     = 1 << AVG_LOG2;
   localparam int SUM_W = DATA_W + AVG_LOG2;
   localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2+1)'(N);
   localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2+1)'(N - 1);

   logic [DATA_W-1:0]   win_q [N];
   logic [AVG_LOG2-1:0] ptr_q;
   logic [AVG_LOG2:0]   fill_q;
   logic [SUM_W-1:0]    sum_q;
   logic [SUM_W-1:0]    sum_d;
   logic [DATA_W-1:0]   avg_q;
   logic                avg_valid_q;

   // New running sum: add incoming sample, drop the one it overwrites.
   always_comb begin
      sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(win_q[ptr_q]);
   end

   // Window, sum, pointer and fill tracking; average strobes only once the window is full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            win_q[i] <= '0;
         end
         ptr_q       <= '0;
         fill_q      <= '0;
         sum_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
      end else if (sample_valid_i) begin
         win_q[ptr_q] <= sample_i;
         sum_q        <= sum_d;
         ptr_q        <= ptr_q + 1'b1;
         if (fill_q != FILL_FULL) begin
            fill_q <= fill_q + 1'b1;
         end
         avg_q       <= sum_d[SUM_W-1:AVG_LOG2];
         avg_valid_q <= (fill_q >= FILL_LAST);
      end else begin
         avg_valid_q <= 1'b0;
      end
   end

   assign avg_valid_o = avg_valid_q;
   assign avg_o       = avg_q;
endmodule

// File: rtl/pressure_alarm_monitor.sv
// rtl/pressure_alarm_monitor.sv - averaged, hysteretic, debounced pressure alarm
module pressure_alarm_monitor
   import pressure_alarm_monitor_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int AVG_LOG2 = 2,
   parameter int DEBOUNCE = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   pressure_alarm_monitor_if.slave bus
);
   localparam int CNT_W = cnt_width(DEBOUNCE);
   localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   logic              avg_valid;
   logic [DATA_W-1:0] avg;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              at_or_above_hi;
   logic              at_or_below_lo;
   logic              alarm_q, alarm_d;
   logic              set_q, set_d;
   logic              clr_q, clr_d;

   pressure_moving_avg #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk            (clk),
      .reset          (reset),
      .sample_valid_i (bus.sample_valid),
      .sample_i       (bus.sample),
      .avg_valid_o    (avg_valid),
      .avg_o          (avg)
   );

   // Next-state, debounce count and alarm edge decode; only moves on a fresh average.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      cnt_inc        = cnt_q + 1'b1;
      at_or_above_hi = (avg >= bus.thresh_hi);
      at_or_below_lo = (avg <= bus.thresh_lo);
      if (avg_valid) begin
         unique case (state_q)
            NORMAL: begin
               if (at_or_above_hi) begin
                  if (DEBOUNCE == 1) begin
                     state_d = ALARM;
                     cnt_d   = '0;
                  end else begin
                     state_d = PEND_HI;
                     cnt_d   = ONE_C;
                  end
               end
            end
            PEND_HI: begin
               if (at_or_above_hi) begin
                  if (cnt_inc == DEB_C) begin
                     state_d = ALARM;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = NORMAL;
                  cnt_d   = '0;
               end
            end
            ALARM: begin
               if (at_or_below_lo) begin
                  if (DEBOUNCE == 1) begin
                     state_d = NORMAL;
                     cnt_d   = '0;
                  end else begin
                     state_d = PEND_LO;
                     cnt_d   = ONE_C;
                  end
               end
            end
            PEND_LO: begin
               if (at_or_below_lo) begin
                  if (cnt_inc == DEB_C) begin
                     state_d = NORMAL;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = ALARM;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = NORMAL;
               cnt_d   = '0;
            end
         endcase
      end
      alarm_d = (state_d == ALARM) || (state_d == PEND_LO);
      set_d   = alarm_d & ~alarm_q;
      clr_d   = ~alarm_d & alarm_q;
   end

   // State, count and registered alarm level with its one-cycle edge pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= NORMAL;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
         set_q   <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
         set_q   <= set_d;
         clr_q   <= clr_d;
      end
   end

   assign bus.avg_out   = avg;
   assign bus.avg_valid = avg_valid;
   assign bus.alarm     = alarm_q;
   assign bus.alarm_set = set_q;
   assign bus.alarm_clr = clr_q;
   assign bus.state_out = state_q;
endmodule

// File: tb/tb_pressure_alarm_monitor.sv
// tb/tb_pressure_alarm_monitor.sv - scoreboard bench for pressure_alarm_monitor
module tb_pressure_alarm_monitor;
   import pressure_alarm_monitor_pkg::*;

   typedef struct {
      int avg;
      int state;
      int alarm;
      int set;
      int clr;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   passes;
   exp_t q[$];
   exp_t pend_e;
   bit   pend;
   int   prev_alarm;

   pressure_alarm_monitor_if #(.DATA_W(12)) bus ();

   pressure_alarm_monitor #(
      .DATA_W   (12),
      .AVG_LOG2 (2),
      .DEBOUNCE (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   // Drive one sample; if an average is due, push the expected average and resulting state.
   task automatic feed(input int s, input bit due, input int ea, input int es);
      exp_t e;
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b1;
      bus.sample       = 12'(s);
      if (due) begin
         e.avg   = ea;
         e.state = es;
         e.alarm = (es == int'(ALARM) || es == int'(PEND_LO)) ? 1 : 0;
         e.set   = (e.alarm == 1 && prev_alarm == 0) ? 1 : 0;
         e.clr   = (e.alarm == 0 && prev_alarm == 1) ? 1 : 0;
         prev_alarm = e.alarm;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " avg_out"},   int'(bus.avg_out),   0);
      chk({tag, " avg_valid"}, int'(bus.avg_valid), 0);
      chk({tag, " alarm"},     int'(bus.alarm),     0);
      chk({tag, " alarm_set"}, int'(bus.alarm_set), 0);
      chk({tag, " alarm_clr"}, int'(bus.alarm_clr), 0);
      chk({tag, " state_out"}, int'(bus.state_out), 0);
   endtask

   // Monitor: compare averages on avg_valid, then the alarm outputs one cycle later.
   always @(negedge clk) begin
      if (reset) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("state_out", int'(bus.state_out), pend_e.state);
            chk("alarm",     int'(bus.alarm),     pend_e.alarm);
            chk("alarm_set", int'(bus.alarm_set), pend_e.set);
            chk("alarm_clr", int'(bus.alarm_clr), pend_e.clr);
            pend = 1'b0;
         end else if (bus.alarm_set || bus.alarm_clr) begin
            chk("stray pulse", 1, 0);
         end
         if (bus.avg_valid) begin
            if (q.size() == 0) begin
               chk("unexpected avg_valid", 1, 0);
            end else begin
               pend_e = q.pop_front();
               chk("avg_out", int'(bus.avg_out), pend_e.avg);
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      int n;
      checks = 0;
      passes = 0;
      pend = 1'b0;
      prev_alarm = 0;
      bus.sample_valid = 1'b0;
      bus.sample       = '0;
      bus.thresh_hi    = 12'd2000;
      bus.thresh_lo    = 12'd1800;

      // 1. reset held with random samples
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         bus.sample_valid = 1'b1;
         bus.sample       = 12'($urandom_range(4095));
      end
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      reset = 1'b0;

      // 2. warm-up: only the fourth sample yields an average
      feed(1000, 0, 0, 0);
      feed(1000, 0, 0, 0);
      feed(1000, 0, 0, 0);
      feed(1000, 1, 1000, NORMAL);

      // 3. alarm set
      feed(2400, 1, 1350, NORMAL);
      feed(2400, 1, 1700, NORMAL);
      feed(2400, 1, 2050, PEND_HI);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, ALARM);
      feed(2400, 1, 2400, ALARM);
      feed(2400, 1, 2400, ALARM);

      // 5. hysteresis clear
      feed(1500, 1, 2175, ALARM);
      feed(1500, 1, 1950, ALARM);
      feed(1500, 1, 1725, PEND_LO);
      feed(1500, 1, 1500, PEND_LO);
      feed(1500, 1, 1500, PEND_LO);
      feed(1500, 1, 1500, PEND_LO);
      feed(1500, 1, 1500, PEND_LO);
      feed(1500, 1, 1500, NORMAL);
      idle(2);

      // 4. spike rejection
      feed(1990, 1, 1622, NORMAL);
      feed(1990, 1, 1745, NORMAL);
      feed(1990, 1, 1867, NORMAL);
      feed(1990, 1, 1990, NORMAL);
      feed(2030, 1, 2000, PEND_HI);
      feed(1990, 1, 2000, PEND_HI);
      feed(1990, 1, 2000, PEND_HI);
      feed(1990, 1, 2000, PEND_HI);
      feed(1990, 1, 1990, NORMAL);

      // 6. reset mid-operation from PEND_HI with count 3
      feed(2400, 1, 2092, PEND_HI);
      feed(2400, 1, 2195, PEND_HI);
      feed(2400, 1, 2297, PEND_HI);
      idle(3);
      #1;
      reset = 1'b1;
      q.delete();
      prev_alarm = 0;
      #1;
      chk_zero("async reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      feed(2400, 0, 0, 0);
      feed(2400, 0, 0, 0);
      feed(2400, 0, 0, 0);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, PEND_HI);
      feed(2400, 1, 2400, ALARM);
      idle(1);

      // drain the scoreboard within a bounded number of cycles
      n = 0;
      while ((q.size() != 0 || pend) && n < 20) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      chk("scoreboard drained", q.size() + int'(pend), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
